// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the memory stage and
// word-wide regions; splits misaligned accesses, reports faults.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready, req_addr, req_we, req_type, req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_fault
//   mem_en (one-hot), mem_we, mem_addr, mem_wdata, mem_rdata
module mem_access_unit #(
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*4-1:0] REGION_IDS =
    {4'h2, 4'h8, 4'h4, 4'h1},
  parameter int RD_LATENCY = 1,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic                      req_we,
  input  logic [2:0]                req_type,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_fault,
  output logic [NUM_REGIONS-1:0]    mem_en,
  output logic [3:0]                mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [NUM_REGIONS*32-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEAT0 = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_BEAT1 = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic        we_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic        mis_q;
  logic [NUM_REGIONS-1:0] en_q;
  logic [31:0] base_q;
  logic [3:0]  strb_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] d0;
  logic [31:0] d1;

  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic        type_ok;
  logic        mis;
  logic [31:0] addr_nx;
  logic        hit0;
  logic        hit1;
  logic [NUM_REGIONS-1:0] en0;
  logic [NUM_REGIONS-1:0] en1;
  logic        fault_dec;
  logic [7:0]  strb_sh;
  logic [63:0] wd_sh;
  logic        accept;

  always_comb begin
    size      = 3'd0;
    size_mask = 4'b0000;
    type_ok   = 1'b1;
    unique case (req_type)
      3'b000, 3'b100: begin
        size      = 3'd1;
        size_mask = 4'b0001;
      end
      3'b001, 3'b101: begin
        size      = 3'd2;
        size_mask = 4'b0011;
      end
      3'b010: begin
        size      = 3'd4;
        size_mask = 4'b1111;
      end
      default: type_ok = 1'b0;
    endcase
  end

  assign mis = ({2'b00, req_addr[1:0]} + {1'b0, size}) > 4'd4;
  assign addr_nx = req_addr + 32'd4;

  // Descending scan so the lowest matching region index wins.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    en0  = '0;
    en1  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (REGION_IDS[i*4 +: 4] == req_addr[31:28]) begin
        hit0   = 1'b1;
        en0    = '0;
        en0[i] = 1'b1;
      end
      if (REGION_IDS[i*4 +: 4] == addr_nx[31:28]) begin
        hit1   = 1'b1;
        en1    = '0;
        en1[i] = 1'b1;
      end
    end
  end

  assign fault_dec = !hit0 || !type_ok ||
    (mis && (!SPLIT_MISALIGNED || !hit1 || (en1 != en0)));

  // Low half feeds beat 0, high half feeds beat 1.
  assign strb_sh = {4'b0000, size_mask} << req_addr[1:0];
  assign wd_sh   = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};

  assign accept = req_valid && req_ready;

  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (en_q[i]) rd_word = mem_rdata[i*32 +: 32];
    end
  end

  logic        last;
  logic [31:0] d0_n;
  logic [31:0] d1_n;
  logic [31:0] raw;
  logic [31:0] ld_res;

  assign last = (cnt == LAST_CNT);
  assign d0_n = (state == S_WAIT0) ? rd_word : d0;
  assign d1_n = (state == S_WAIT1) ? rd_word : d1;
  assign raw  = 32'({d1_n, d0_n} >> {off_q, 3'b000});

  always_comb begin
    ld_res = raw;
    unique case (type_q)
      3'b000:  ld_res = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ld_res = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ld_res = {24'h0, raw[7:0]};
      3'b101:  ld_res = {16'h0, raw[15:0]};
      default: ld_res = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      type_q    <= '0;
      off_q     <= '0;
      mis_q     <= 1'b0;
      en_q      <= '0;
      base_q    <= '0;
      strb_hi_q <= '0;
      wd_hi_q   <= '0;
      d0        <= '0;
      d1        <= '0;
    end else begin
      mem_en <= '0;
      mem_we <= '0;
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            type_q    <= req_type;
            off_q     <= req_addr[1:0];
            mis_q     <= mis;
            en_q      <= en0;
            base_q    <= {req_addr[31:2], 2'b00};
            strb_hi_q <= strb_sh[7:4];
            wd_hi_q   <= wd_sh[63:32];
            d1        <= '0;
            cnt       <= '0;
            if (fault_dec) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= S_BEAT0;
              mem_en   <= en0;
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we) begin
                mem_we    <= strb_sh[3:0];
                mem_wdata <= wd_sh[31:0];
              end
            end
          end
        end
        S_BEAT0: begin
          if (!we_q) begin
            state <= S_WAIT0;
            cnt   <= '0;
          end else if (mis_q) begin
            state     <= S_BEAT1;
            mem_en    <= en_q;
            mem_addr  <= base_q + 32'd4;
            mem_we    <= strb_hi_q;
            mem_wdata <= wd_hi_q;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        S_WAIT0: begin
          if (last) begin
            d0 <= rd_word;
            if (mis_q) begin
              state    <= S_BEAT1;
              mem_en   <= en_q;
              mem_addr <= base_q + 32'd4;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_rdata <= ld_res;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_BEAT1: begin
          if (we_q) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= S_WAIT1;
            cnt   <= '0;
          end
        end
        S_WAIT1: begin
          if (last) begin
            d1        <= rd_word;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= ld_res;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit
// with a byte-strobed memory model behind four regions.
module tb_mem_access_unit;

  localparam int NR = 4;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_addr = '0;
  logic req_we = 1'b0;
  logic [2:0] req_type = '0;
  logic [31:0] req_wdata = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic rsp_fault;
  logic [NR-1:0] mem_en;
  logic [3:0] mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [NR*32-1:0] mem_rdata = '0;

  logic ns_req_valid = 1'b0;
  logic ns_req_ready;
  logic [31:0] ns_req_addr = '0;
  logic ns_rsp_valid;
  logic ns_rsp_ready = 1'b1;
  logic [31:0] ns_rsp_rdata;
  logic ns_rsp_fault;
  logic [NR-1:0] ns_mem_en;
  logic [3:0] ns_mem_we;
  logic [31:0] ns_mem_addr;
  logic [31:0] ns_mem_wdata;
  logic [NR*32-1:0] ns_mem_rdata = '0;

  mem_access_unit #(
    .NUM_REGIONS(NR), .REGION_IDS(16'h2841),
    .RD_LATENCY(1), .SPLIT_MISALIGNED(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we),
    .req_type(req_type), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(
    .NUM_REGIONS(NR), .REGION_IDS(16'h2841),
    .RD_LATENCY(1), .SPLIT_MISALIGNED(1'b0)
  ) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_addr(ns_req_addr), .req_we(1'b0),
    .req_type(LW), .req_wdata(32'h0),
    .rsp_valid(ns_rsp_valid), .rsp_ready(ns_rsp_ready),
    .rsp_rdata(ns_rsp_rdata), .rsp_fault(ns_rsp_fault),
    .mem_en(ns_mem_en), .mem_we(ns_mem_we),
    .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
    .mem_rdata(ns_mem_rdata)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ns_beats = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } rsp_t;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
  } beat_t;

  rsp_t  exp_q[$];
  beat_t beat_q[$];
  rsp_t  cur;
  logic  in_rsp = 1'b0;
  logic  have_cur = 1'b0;
  logic  hs_prev = 1'b0;

  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (mem_en[i]) begin
        if (mem_we != 4'b0000) begin
          logic [31:0] w;
          w = rdm(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = w;
        end else begin
          mem_rdata[32*i +: 32] <= rdm(mem_addr);
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    hs_prev <= rst && rsp_valid && rsp_ready;
  end

  always @(negedge clk) begin
    if (ns_mem_en != '0) ns_beats++;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (hs_prev)
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
      if (!rsp_valid) begin
        in_rsp   = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: rdata %h fault %b, none expected",
                     rsp_rdata, rsp_fault);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("rsp_latency", 32'(cyc), 32'(cur.due));
          end
        end
        if (have_cur) begin
          chk("rsp_rdata", rsp_rdata, cur.rdata);
          chk("rsp_fault", 32'(rsp_fault), 32'(cur.fault));
          chk("busy_req_ready", 32'(req_ready), 32'd0);
        end
      end
      if (mem_en != '0) begin
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: en %b addr %h, none expected",
                   mem_en, mem_addr);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_en", 32'(mem_en), 32'(b.en));
          chk("beat_we", 32'(mem_we), 32'(b.we));
          chk("beat_addr", mem_addr, b.addr);
          if (b.we != 4'b0000) chk("beat_wdata", mem_wdata, b.wd);
        end
      end
    end
  end

  task automatic bt(input logic [3:0] en, input logic [3:0] we,
                    input logic [31:0] a, input logic [31:0] wd);
    beat_t b;
    b.en = en; b.we = we; b.addr = a; b.wd = wd;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic [31:0] a, input logic we,
                       input logic [2:0] ty, input logic [31:0] wd,
                       input logic [31:0] er, input logic ef,
                       input int lat);
    int n;
    rsp_t e;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: addr %h req_ready %b want 1",
               a, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_type  = ty;
    req_wdata = wd;
    e.rdata = er;
    e.fault = ef;
    e.due   = cyc + lat;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0 ||
            rsp_valid || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: rsp left %0d beats left %0d want 0",
               exp_q.size(), beat_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h1000_0010] = 32'hDEAD_BEEF;
    mem[32'h1000_0000] = 32'h80FF_FFFF;
    mem[32'h4000_0000] = 32'h4433_2211;
    mem[32'h4000_0004] = 32'h8877_6655;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("ns_req_ready", 32'(ns_req_ready), 32'd1);
    ns_req_valid = 1'b1;
    ns_req_addr  = 32'h4000_0001;
    @(negedge clk);
    ns_req_valid = 1'b0;
    chk("ns_rsp_valid", 32'(ns_rsp_valid), 32'd1);
    chk("ns_rsp_fault", 32'(ns_rsp_fault), 32'd1);
    chk("ns_rsp_rdata", ns_rsp_rdata, 32'h0);

    bt(4'b0001, 4'b0000, 32'h1000_0010, 32'h0);
    issue(32'h1000_0010, 1'b0, LW, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    bt(4'b0001, 4'b0000, 32'h1000_0000, 32'h0);
    issue(32'h1000_0003, 1'b0, LB, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    bt(4'b0001, 4'b0000, 32'h1000_0000, 32'h0);
    issue(32'h1000_0003, 1'b0, LBU, 32'h0, 32'h0000_0080, 1'b0, 3);
    drain();

    bt(4'b0001, 4'b1100, 32'h1000_0000, 32'hCCDD_0000);
    bt(4'b0001, 4'b0011, 32'h1000_0004, 32'h0000_AABB);
    issue(32'h1000_0002, 1'b1, LW, 32'hAABB_CCDD, 32'h0, 1'b0, 3);
    bt(4'b0001, 4'b0000, 32'h1000_0000, 32'h0);
    bt(4'b0001, 4'b0000, 32'h1000_0004, 32'h0);
    issue(32'h1000_0002, 1'b0, LW, 32'h0, 32'hAABB_CCDD, 1'b0, 5);
    drain();

    bt(4'b0010, 4'b0000, 32'h4000_0000, 32'h0);
    bt(4'b0010, 4'b0000, 32'h4000_0004, 32'h0);
    issue(32'h4000_0001, 1'b0, LW, 32'h0, 32'h5544_3322, 1'b0, 5);
    bt(4'b0010, 4'b0000, 32'h4000_0004, 32'h0);
    issue(32'h4000_0006, 1'b0, LH, 32'h0, 32'hFFFF_8877, 1'b0, 3);
    bt(4'b0010, 4'b0000, 32'h4000_0004, 32'h0);
    issue(32'h4000_0006, 1'b0, LHU, 32'h0, 32'h0000_8877, 1'b0, 3);
    bt(4'b0010, 4'b0000, 32'h4000_0000, 32'h0);
    bt(4'b0010, 4'b0000, 32'h4000_0004, 32'h0);
    issue(32'h4000_0003, 1'b0, LH, 32'h0, 32'h0000_5544, 1'b0, 5);
    drain();

    bt(4'b0100, 4'b0010, 32'h8000_0000, 32'h3456_A500);
    issue(32'h8000_0001, 1'b1, LB, 32'h1234_56A5, 32'h0, 1'b0, 2);
    bt(4'b0100, 4'b0000, 32'h8000_0000, 32'h0);
    issue(32'h8000_0001, 1'b0, LBU, 32'h0, 32'h0000_00A5, 1'b0, 3);
    bt(4'b0100, 4'b0000, 32'h8000_0000, 32'h0);
    issue(32'h8000_0001, 1'b0, LB, 32'h0, 32'hFFFF_FFA5, 1'b0, 3);
    drain();

    bt(4'b1000, 4'b1000, 32'h2000_0000, 32'hEF00_0000);
    bt(4'b1000, 4'b0001, 32'h2000_0004, 32'h0000_00BE);
    issue(32'h2000_0003, 1'b1, LH, 32'h0000_BEEF, 32'h0, 1'b0, 3);
    bt(4'b1000, 4'b0000, 32'h2000_0000, 32'h0);
    issue(32'h2000_0000, 1'b0, LW, 32'h0, 32'hEF00_0000, 1'b0, 3);
    bt(4'b1000, 4'b0000, 32'h2000_0000, 32'h0);
    bt(4'b1000, 4'b0000, 32'h2000_0004, 32'h0);
    issue(32'h2000_0003, 1'b0, LHU, 32'h0, 32'h0000_BEEF, 1'b0, 5);
    drain();

    issue(32'hFFFF_FFFD, 1'b0, LW, 32'h0, 32'h0, 1'b1, 1);
    issue(32'h1FFF_FFFE, 1'b0, LW, 32'h0, 32'h0, 1'b1, 1);
    issue(32'h1000_0000, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1);
    issue(32'h1000_0000, 1'b1, 3'b110, 32'h1, 32'h0, 1'b1, 1);
    drain();

    rsp_ready = 1'b0;
    issue(32'h7000_0000, 1'b0, LB, 32'h0, 32'h0, 1'b1, 1);
    req_valid = 1'b1;
    req_addr  = 32'h1000_0010;
    req_we    = 1'b0;
    req_type  = LW;
    for (int k = 0; k < 3; k++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    bt(4'b0010, 4'b0000, 32'h4000_0000, 32'h0);
    bt(4'b0010, 4'b0000, 32'h4000_0004, 32'h0);
    issue(32'h4000_0000, 1'b0, LW, 32'h0, 32'h4433_2211, 1'b0, 3);
    issue(32'h4000_0004, 1'b0, LW, 32'h0, 32'h8877_6655, 1'b0, 3);
    drain();

    bt(4'b0001, 4'b0000, 32'h1000_0010, 32'h0);
    req_valid = 1'b1;
    req_addr  = 32'h1000_0010;
    req_we    = 1'b0;
    req_type  = LW;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("drop_mem_en", 32'(mem_en), 32'd0);
    chk("drop_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("drop_idle_ready", 32'(req_ready), 32'd1);
    chk("drop_beats_left", 32'(beat_q.size()), 32'd0);
    chk("ns_no_beats", 32'(ns_beats), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
